// File: rtl/digpot_pkg.sv
// Shared definitions for the three-wire digital-potentiometer controller and wiper model.
package digpot_pkg;

  localparam int unsigned TAPS_DEFAULT = 100;
  localparam int unsigned WIDTH        = 7;
  localparam logic [6:0]  MAX_TAP      = 7'd99;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEL,
    ST_STORE
  } digpot_state_e;

endpackage

// File: rtl/digpot_sync.sv
// Multi-stage synchronizer for an asynchronous control line; resets to 1 (lines idle high).
module digpot_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/digpot_wiper_model.sv
// X9C-style responder: tracks a saturating wiper from CS/INC/U_D and emulates
// store-on-deselect into a nonvolatile register when DIGPOT_STORE_EN is defined.
module digpot_wiper_model
  import digpot_pkg::*;
#(
  parameter int unsigned TAPS         = TAPS_DEFAULT,
  parameter int unsigned WIDTH        = digpot_pkg::WIDTH,
  parameter int unsigned DEFAULT_TAP  = 50,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned STORE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs_in,
  input  logic             inc_in,
  input  logic             ud_in,
  output logic [WIDTH-1:0] wiper,
  output logic             step,
  output logic             at_min,
  output logic             at_max,
  output logic             store_busy
);

  localparam logic [WIDTH-1:0] TOP_TAP  = WIDTH'(TAPS - 1);
  localparam logic [WIDTH-1:0] INIT_TAP = WIDTH'(DEFAULT_TAP);
  localparam int unsigned      CNT_W    = (STORE_CYCLES > 1) ? $clog2(STORE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STORE_CYCLES - 1);

  logic cs_s, inc_s, ud_s;
  logic cs_d_q, inc_d_q;
  logic inc_fall, cs_rise;

  digpot_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] wiper_q, wiper_d;
  logic             step_q, step_en;
  logic             store_go;

  digpot_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (cs_in),
    .q_o   (cs_s)
  );

  digpot_sync #(.STAGES(SYNC_STAGES)) u_sync_inc (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (inc_in),
    .q_o   (inc_s)
  );

  digpot_sync #(.STAGES(SYNC_STAGES)) u_sync_ud (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (ud_in),
    .q_o   (ud_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_d_q  <= 1'b1;
      inc_d_q <= 1'b1;
    end else begin
      cs_d_q  <= cs_s;
      inc_d_q <= inc_s;
    end
  end

  assign inc_fall = inc_d_q & ~inc_s;
  assign cs_rise  = ~cs_d_q & cs_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!cs_s) state_d = ST_SEL;
      end
      ST_SEL: begin
        if (cs_rise) begin
`ifdef DIGPOT_STORE_EN
          state_d = inc_s ? ST_STORE : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_STORE: begin
        if (cnt_q == CNT_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic; saturation is checked before the add so the
  // increment never reaches 2**WIDTH.
  always_comb begin
    step_en  = (state_q == ST_SEL) && inc_fall;
    wiper_d  = wiper_q;
    cnt_d    = '0;
    store_go = (state_q == ST_SEL) && (state_d == ST_STORE);
    if (step_en) begin
      if (ud_s) begin
        if (wiper_q < TOP_TAP) wiper_d = wiper_q + 1'b1;
      end else begin
        if (wiper_q != '0) wiper_d = wiper_q - 1'b1;
      end
    end
    if (state_q == ST_STORE) cnt_d = cnt_q + 1'b1;
  end

`ifdef DIGPOT_STORE_EN
  // Nonvolatile copy survives rst; captures the already-stepped wiper on store entry.
  logic [WIDTH-1:0] nv_q = INIT_TAP;

  always_ff @(posedge clk) begin
    if (store_go) nv_q <= wiper_d;
  end

  assign store_busy = (state_q == ST_STORE);
`else
  logic [WIDTH-1:0] nv_q;

  assign nv_q       = INIT_TAP;
  assign store_busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wiper_q <= nv_q;
      step_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wiper_q <= wiper_d;
      step_q  <= step_en;
      cnt_q   <= cnt_d;
    end
  end

  assign wiper  = wiper_q;
  assign step   = step_q;
  assign at_min = (wiper_q == '0);
  assign at_max = (wiper_q == TOP_TAP);

endmodule

// File: tb/tb_digpot_wiper_model.sv
// Directed self-checking bench for digpot_wiper_model; follows DIGPOT_STORE_EN like the RTL.
module tb_digpot_wiper_model;

`ifdef DIGPOT_STORE_EN
  localparam bit STORE_EN = 1'b1;
`else
  localparam bit STORE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_in = 1'b1;
  logic       inc_in = 1'b1;
  logic       ud_in = 1'b1;
  logic [6:0] wiper;
  logic       step, at_min, at_max, store_busy;

  int checks = 0;
  int errors = 0;
  int nv_exp = 50;

  always #5 clk = ~clk;

  digpot_wiper_model #(
    .TAPS         (100),
    .WIDTH        (7),
    .DEFAULT_TAP  (50),
    .SYNC_STAGES  (2),
    .STORE_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cs_in      (cs_in),
    .inc_in     (inc_in),
    .ud_in      (ud_in),
    .wiper      (wiper),
    .step       (step),
    .at_min     (at_min),
    .at_max     (at_max),
    .store_busy (store_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // One inc_in pulse; reports step pulses seen and cycles from pin edge to first step.
  task automatic pulse(input logic up, output int nsteps, output int lat);
    @(negedge clk);
    ud_in = up;
    @(negedge clk);
    inc_in = 1'b0;
    nsteps = 0;
    lat = -1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (step) begin
        nsteps++;
        if (lat < 0) lat = k;
      end
    end
    @(negedge clk);
    inc_in = 1'b1;
    for (int k = 5; k <= 8; k++) begin
      tick();
      if (step) nsteps++;
    end
  endtask

  task automatic move(input logic up, input int n);
    int s, l;
    for (int i = 0; i < n; i++) pulse(up, s, l);
  endtask

  task automatic select();
    @(negedge clk);
    cs_in = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (wiper !== 7'd50) begin errors++; $display("FAIL reset_wiper got %0d exp 50", wiper); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step got %b exp 0", step); end
    checks++; if (at_min !== 1'b0) begin errors++; $display("FAIL reset_at_min got %b exp 0", at_min); end
    checks++; if (at_max !== 1'b0) begin errors++; $display("FAIL reset_at_max got %b exp 0", at_max); end
    checks++; if (store_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", store_busy); end
  endtask

  task automatic test_up_steps();
    int s, l;
    select();
    for (int i = 0; i < 10; i++) begin
      pulse(1'b1, s, l);
      checks++; if (s != 1) begin errors++; $display("FAIL up_step_count[%0d] got %0d exp 1", i, s); end
      checks++; if (l != 3) begin errors++; $display("FAIL up_step_latency[%0d] got %0d exp 3", i, l); end
    end
    checks++; if (wiper !== 7'd60) begin errors++; $display("FAIL up_wiper got %0d exp 60", wiper); end
  endtask

  task automatic test_saturation();
    int s, l, total;
    move(1'b1, 38);
    checks++; if (wiper !== 7'd98) begin errors++; $display("FAIL sat_pre_up got %0d exp 98", wiper); end
    checks++; if (at_max !== 1'b0) begin errors++; $display("FAIL sat_at_max_98 got %b exp 0", at_max); end
    total = 0;
    for (int i = 0; i < 3; i++) begin pulse(1'b1, s, l); total += s; end
    checks++; if (total != 3) begin errors++; $display("FAIL sat_up_steps got %0d exp 3", total); end
    checks++; if (wiper !== 7'd99) begin errors++; $display("FAIL sat_up_wiper got %0d exp 99", wiper); end
    checks++; if (at_max !== 1'b1) begin errors++; $display("FAIL sat_at_max got %b exp 1", at_max); end
    move(1'b0, 98);
    checks++; if (wiper !== 7'd1) begin errors++; $display("FAIL sat_pre_down got %0d exp 1", wiper); end
    checks++; if (at_min !== 1'b0) begin errors++; $display("FAIL sat_at_min_1 got %b exp 0", at_min); end
    total = 0;
    for (int i = 0; i < 3; i++) begin pulse(1'b0, s, l); total += s; end
    checks++; if (total != 3) begin errors++; $display("FAIL sat_down_steps got %0d exp 3", total); end
    checks++; if (wiper !== 7'd0) begin errors++; $display("FAIL sat_down_wiper got %0d exp 0", wiper); end
    checks++; if (at_min !== 1'b1) begin errors++; $display("FAIL sat_at_min got %b exp 1", at_min); end
  endtask

  task automatic test_store();
    int busy, steps;
    move(1'b1, 72);
    checks++; if (wiper !== 7'd72) begin errors++; $display("FAIL store_pre_wiper got %0d exp 72", wiper); end
    @(negedge clk);
    cs_in = 1'b1;
    busy = 0;
    steps = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (store_busy) busy++;
      if (step) steps++;
      if (k == 8) inc_in = 1'b0;
      if (k == 12) inc_in = 1'b1;
    end
    checks++; if (busy != (STORE_EN ? 16 : 0)) begin errors++; $display("FAIL store_busy_cycles got %0d exp %0d", busy, STORE_EN ? 16 : 0); end
    checks++; if (steps != 0) begin errors++; $display("FAIL store_ignored_steps got %0d exp 0", steps); end
    checks++; if (wiper !== 7'd72) begin errors++; $display("FAIL store_hold_wiper got %0d exp 72", wiper); end
    nv_exp = STORE_EN ? 72 : 50;
    do_reset();
    checks++; if (wiper !== 7'(nv_exp)) begin errors++; $display("FAIL store_reload got %0d exp %0d", wiper, nv_exp); end
  endtask

  task automatic test_deselect_no_store();
    int busy, steps;
    select();
    move(1'b1, 3);
    checks++; if (wiper !== 7'(nv_exp + 3)) begin errors++; $display("FAIL desel_pre got %0d exp %0d", wiper, nv_exp + 3); end
    // Simultaneous inc fall and cs rise: step applies, inc low means no store.
    @(negedge clk);
    ud_in = 1'b1;
    @(negedge clk);
    inc_in = 1'b0;
    cs_in = 1'b1;
    busy = 0;
    steps = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (store_busy) busy++;
      if (step) steps++;
    end
    checks++; if (busy != 0) begin errors++; $display("FAIL desel_busy got %0d exp 0", busy); end
    checks++; if (steps != 1) begin errors++; $display("FAIL desel_steps got %0d exp 1", steps); end
    checks++; if (wiper !== 7'(nv_exp + 4)) begin errors++; $display("FAIL desel_wiper got %0d exp %0d", wiper, nv_exp + 4); end
    @(negedge clk);
    inc_in = 1'b1;
    repeat (4) tick();
    do_reset();
    checks++; if (wiper !== 7'(nv_exp)) begin errors++; $display("FAIL desel_reload got %0d exp %0d", wiper, nv_exp); end
  endtask

  task automatic test_idle_inc();
    int s, l;
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, s, l);
      checks++; if (s != 0) begin errors++; $display("FAIL idle_step[%0d] got %0d exp 0", i, s); end
    end
    checks++; if (wiper !== 7'(nv_exp)) begin errors++; $display("FAIL idle_wiper got %0d exp %0d", wiper, nv_exp); end
  endtask

  task automatic test_mid_store_reset();
    int s, l, w;
    select();
    pulse(1'b1, s, l);
    w = nv_exp + 1;
    checks++; if (wiper !== 7'(w)) begin errors++; $display("FAIL mid_pre got %0d exp %0d", wiper, w); end
    @(negedge clk);
    cs_in = 1'b1;
    for (int k = 1; k <= 7; k++) tick();
    checks++; if (store_busy !== STORE_EN) begin errors++; $display("FAIL mid_busy_c5 got %b exp %b", store_busy, STORE_EN); end
    rst = 1'b1;
    tick();
    checks++; if (store_busy !== 1'b0) begin errors++; $display("FAIL mid_abort_busy got %b exp 0", store_busy); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (store_busy !== 1'b0) begin errors++; $display("FAIL mid_idle_busy got %b exp 0", store_busy); end
    nv_exp = STORE_EN ? w : 50;
    checks++; if (wiper !== 7'(nv_exp)) begin errors++; $display("FAIL mid_reload got %0d exp %0d", wiper, nv_exp); end
  endtask

  initial begin
    test_reset();
    test_up_steps();
    test_saturation();
    test_store();
    test_deselect_no_store();
    test_idle_inc();
    test_mid_store_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
